// File: rtl/dma_write_arbiter_pkg.sv
// Shared types and limits for the DMA write arbiter slice.
// Holds the arbiter FSM state encoding and the supported upper bound on upstream ports.
package circular_dma_pkg;

  localparam int C_MAX_PORTS = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } state_t;

endpackage

// File: rtl/dma_write_arbiter_rr_select.sv
// Combinational round-robin winner search: first requester at or above the
// pointer, wrapping from the top port back to port 0.
module rr_select #(
  parameter  int C_NUM_PORTS = 4,
  localparam int C_IDX_W     = $clog2(C_NUM_PORTS)
) (
  input  logic [C_NUM_PORTS-1:0] i_req,
  input  logic [C_IDX_W-1:0]     i_ptr,
  output logic                   o_valid,
  output logic [C_IDX_W-1:0]     o_index
);

  logic [C_IDX_W-1:0] w_cand;

  // Walk offsets from farthest to nearest so the closest requester is the last one kept.
  always_comb begin
    o_valid = 1'b0;
    o_index = '0;
    w_cand  = '0;
    for (int k = C_NUM_PORTS - 1; k >= 0; k--) begin
      w_cand = C_IDX_W'((int'(i_ptr) + k) % C_NUM_PORTS);
      if (i_req[w_cand]) begin
        o_valid = 1'b1;
        o_index = w_cand;
      end
    end
  end

endmodule

// File: rtl/dma_write_arbiter.sv
// Round-robin arbiter merging several upstream AXI write ports onto one
// downstream port, one whole transaction (AW, W burst, B) at a time.
module dma_write_arbiter
  import circular_dma_pkg::*;
#(
  parameter  int C_NUM_PORTS  = 4,
  parameter  int C_ADDR_WIDTH = 32,
  parameter  int C_AXI_WIDTH  = 64,
  localparam int C_IDX_W      = $clog2(C_NUM_PORTS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [C_ADDR_WIDTH-1:0] s_axi_awaddr [C_NUM_PORTS],
  input  logic [7:0]              s_axi_awlen  [C_NUM_PORTS],
  input  logic [C_NUM_PORTS-1:0]  s_axi_awvalid,
  output logic [C_NUM_PORTS-1:0]  s_axi_awready,
  input  logic [C_AXI_WIDTH-1:0]  s_axi_wdata  [C_NUM_PORTS],
  input  logic [C_NUM_PORTS-1:0]  s_axi_wlast,
  input  logic [C_NUM_PORTS-1:0]  s_axi_wvalid,
  output logic [C_NUM_PORTS-1:0]  s_axi_wready,
  output logic [1:0]              s_axi_bresp  [C_NUM_PORTS],
  output logic [C_NUM_PORTS-1:0]  s_axi_bvalid,
  input  logic [C_NUM_PORTS-1:0]  s_axi_bready,
  output logic [C_ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [C_AXI_WIDTH-1:0]  m_axi_wdata,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic                    grant_valid,
  output logic [C_IDX_W-1:0]      grant_id,
  output logic [C_NUM_PORTS-1:0]  wlast_error,
  input  logic [C_NUM_PORTS-1:0]  clear_error
);

  state_t                 r_state;
  logic [C_IDX_W-1:0]     r_rr_ptr;
  logic [C_IDX_W-1:0]     r_grant_id;
  logic                   r_grant_valid;
  logic [C_NUM_PORTS-1:0] r_wlast_error;
  logic [7:0]             r_beat_cnt;
  logic [7:0]             r_awlen;

  logic                   w_sel_valid;
  logic [C_IDX_W-1:0]     w_sel_idx;
  logic                   w_aw_hs;
  logic                   w_w_hs;
  logic                   w_b_hs;
  logic [C_NUM_PORTS-1:0] w_err_set;

  rr_select #(
    .C_NUM_PORTS(C_NUM_PORTS)
  ) u_rr_select (
    .i_req  (s_axi_awvalid),
    .i_ptr  (r_rr_ptr),
    .o_valid(w_sel_valid),
    .o_index(w_sel_idx)
  );

  // Downstream mirrors the owner; valids are gated by phase so stale data never leaks out.
  always_comb begin
    m_axi_awaddr  = s_axi_awaddr[r_grant_id];
    m_axi_awlen   = s_axi_awlen[r_grant_id];
    m_axi_awvalid = (r_state == ST_ADDR) && s_axi_awvalid[r_grant_id];
    m_axi_wdata   = s_axi_wdata[r_grant_id];
    m_axi_wvalid  = (r_state == ST_DATA) && s_axi_wvalid[r_grant_id];
    m_axi_wlast   = (r_state == ST_DATA) && (r_beat_cnt == r_awlen);
    m_axi_bready  = (r_state == ST_RESP) && s_axi_bready[r_grant_id];
    s_axi_awready = '0;
    s_axi_wready  = '0;
    s_axi_bvalid  = '0;
    for (int p = 0; p < C_NUM_PORTS; p++) begin
      s_axi_bresp[p] = 2'b00;
    end
    case (r_state)
      ST_ADDR: s_axi_awready[r_grant_id] = m_axi_awready;
      ST_DATA: s_axi_wready[r_grant_id]  = m_axi_wready;
      ST_RESP: begin
        s_axi_bvalid[r_grant_id] = m_axi_bvalid;
        s_axi_bresp[r_grant_id]  = m_axi_bresp;
      end
      default: ;
    endcase
  end

  assign w_aw_hs = m_axi_awvalid && m_axi_awready;
  assign w_w_hs  = m_axi_wvalid && m_axi_wready;
  assign w_b_hs  = m_axi_bvalid && m_axi_bready;

  // The source's own wlast is only audited; the downstream wlast comes from our beat count.
  always_comb begin
    w_err_set = '0;
    if (w_w_hs && (s_axi_wlast[r_grant_id] != m_axi_wlast)) begin
      w_err_set[r_grant_id] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_rr_ptr      <= '0;
      r_grant_id    <= '0;
      r_grant_valid <= 1'b0;
      r_wlast_error <= '0;
      r_beat_cnt    <= '0;
      r_awlen       <= '0;
    end else begin
      r_wlast_error <= (r_wlast_error & ~clear_error) | w_err_set;
      case (r_state)
        ST_IDLE: begin
          if (w_sel_valid) begin
            r_grant_id    <= w_sel_idx;
            r_grant_valid <= 1'b1;
            r_state       <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (w_aw_hs) begin
            r_awlen    <= s_axi_awlen[r_grant_id];
            r_beat_cnt <= '0;
            r_state    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_w_hs) begin
            r_beat_cnt <= r_beat_cnt + 8'd1;
            if (m_axi_wlast) begin
              r_state <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          if (w_b_hs) begin
            r_state       <= ST_IDLE;
            r_grant_valid <= 1'b0;
            r_rr_ptr      <= (r_grant_id == C_IDX_W'(C_NUM_PORTS - 1)) ? '0 : r_grant_id + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign grant_valid = r_grant_valid;
  assign grant_id    = r_grant_id;
  assign wlast_error = r_wlast_error;

endmodule

// File: tb/tb_dma_write_arbiter.sv
// Directed, table-driven bench for dma_write_arbiter: each table row is one
// full AW/W/B transaction with its hand-computed winner, bresp and error state.
module tb_dma_write_arbiter;

  localparam int NP = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] s_axi_awaddr [NP];
  logic [7:0]  s_axi_awlen  [NP];
  logic [NP-1:0] s_axi_awvalid;
  logic [NP-1:0] s_axi_awready;
  logic [63:0] s_axi_wdata  [NP];
  logic [NP-1:0] s_axi_wlast;
  logic [NP-1:0] s_axi_wvalid;
  logic [NP-1:0] s_axi_wready;
  logic [1:0]  s_axi_bresp  [NP];
  logic [NP-1:0] s_axi_bvalid;
  logic [NP-1:0] s_axi_bready;
  logic [31:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic        m_axi_awvalid;
  logic        m_axi_awready;
  logic [63:0] m_axi_wdata;
  logic        m_axi_wlast;
  logic        m_axi_wvalid;
  logic        m_axi_wready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid;
  logic        m_axi_bready;
  logic        grant_valid;
  logic [1:0]  grant_id;
  logic [NP-1:0] wlast_error;
  logic [NP-1:0] clear_error;

  int nChecks = 0;
  int nPass   = 0;

  typedef struct {
    logic [3:0] mask;
    logic [7:0] awlen;
    int         srcLast;
    logic [1:0] bresp;
    int         expGrant;
    int         clrBeat;
    int         stall;
    logic [3:0] expErr;
  } vec_t;

  vec_t vecs [16];

  dma_write_arbiter #(
    .C_NUM_PORTS (NP),
    .C_ADDR_WIDTH(32),
    .C_AXI_WIDTH (64)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_axi_awaddr (s_axi_awaddr),
    .s_axi_awlen  (s_axi_awlen),
    .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_wdata  (s_axi_wdata),
    .s_axi_wlast  (s_axi_wlast),
    .s_axi_wvalid (s_axi_wvalid),
    .s_axi_wready (s_axi_wready),
    .s_axi_bresp  (s_axi_bresp),
    .s_axi_bvalid (s_axi_bvalid),
    .s_axi_bready (s_axi_bready),
    .m_axi_awaddr (m_axi_awaddr),
    .m_axi_awlen  (m_axi_awlen),
    .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready),
    .m_axi_wdata  (m_axi_wdata),
    .m_axi_wlast  (m_axi_wlast),
    .m_axi_wvalid (m_axi_wvalid),
    .m_axi_wready (m_axi_wready),
    .m_axi_bresp  (m_axi_bresp),
    .m_axi_bvalid (m_axi_bvalid),
    .m_axi_bready (m_axi_bready),
    .grant_valid  (grant_valid),
    .grant_id     (grant_id),
    .wlast_error  (wlast_error),
    .clear_error  (clear_error)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    nChecks++;
    if (actual === expected) begin
      nPass++;
    end else begin
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [63:0] beatData(input int port, input int beat);
    return 64'hD000_0000_0000_0000 | 64'(port << 8) | 64'(beat);
  endfunction

  // One full transaction: wait for the grant, AW handshake, every W beat, then B.
  task automatic applyStimulus(input vec_t v);
    int         g;
    int         waited;
    logic [3:0] oneHot;
    g      = v.expGrant;
    oneHot = 4'b0001 << g;
    s_axi_awlen[g] = v.awlen;
    s_axi_awvalid  = s_axi_awvalid | v.mask;
    waited = 0;
    do begin
      tick();
      waited++;
    end while (!grant_valid && waited < 10);
    checkOutput("grantLatency", 64'(waited), 64'd1);
    checkOutput("grantId", 64'(grant_id), 64'(g));
    checkOutput("mAwvalid", 64'(m_axi_awvalid), 64'd1);
    checkOutput("mAwaddr", 64'(m_axi_awaddr), 64'(32'h1000_0000 + 32'(g) * 32'h100));
    checkOutput("mAwlen", 64'(m_axi_awlen), 64'(v.awlen));
    m_axi_awready = 1'b1;
    #1;
    checkOutput("sAwready", 64'(s_axi_awready), 64'(oneHot));
    tick();
    s_axi_awvalid[g] = 1'b0;
    m_axi_awready    = 1'b0;
    for (int b = 0; b <= int'(v.awlen); b++) begin
      s_axi_wvalid[g] = 1'b1;
      s_axi_wdata[g]  = beatData(g, b);
      s_axi_wlast[g]  = (b == v.srcLast);
      clear_error     = (b == v.clrBeat) ? oneHot : 4'b0000;
      m_axi_wready    = !(b == 0 && v.stall > 0);
      #1;
      if (b == 0) begin
        for (int s = 0; s < v.stall; s++) begin
          checkOutput("stallWvalid", 64'(m_axi_wvalid), 64'd1);
          checkOutput("stallWdata", m_axi_wdata, beatData(g, 0));
          checkOutput("stallWlast", 64'(m_axi_wlast), 64'(v.awlen == 8'd0));
          checkOutput("stallSWready", 64'(s_axi_wready), 64'd0);
          tick();
          clear_error = 4'b0000;
        end
        m_axi_wready = 1'b1;
        #1;
      end
      checkOutput("mWvalid", 64'(m_axi_wvalid), 64'd1);
      checkOutput("mWdata", m_axi_wdata, beatData(g, b));
      checkOutput("mWlast", 64'(m_axi_wlast), 64'(b == int'(v.awlen)));
      checkOutput("sWready", 64'(s_axi_wready), 64'(oneHot));
      tick();
      clear_error = 4'b0000;
    end
    s_axi_wvalid[g] = 1'b0;
    s_axi_wlast[g]  = 1'b0;
    m_axi_wready    = 1'b0;
    m_axi_bvalid    = 1'b1;
    m_axi_bresp     = v.bresp;
    s_axi_bready[g] = 1'b1;
    #1;
    checkOutput("mBready", 64'(m_axi_bready), 64'd1);
    checkOutput("sBresp", 64'(s_axi_bresp[g]), 64'(v.bresp));
    checkOutput("sBvalid", 64'(s_axi_bvalid), 64'(oneHot));
    tick();
    m_axi_bvalid    = 1'b0;
    m_axi_bresp     = 2'b00;
    s_axi_bready[g] = 1'b0;
    #1;
    checkOutput("grantReleased", 64'(grant_valid), 64'd0);
    checkOutput("wlastError", 64'(wlast_error), 64'(v.expErr));
  endtask

  initial begin
    // Rows: mask, awlen, srcLast beat, bresp, winner, clear beat, stall, error vector after.
    vecs[0]  = '{4'b1111, 8'd3, 3, 2'b00, 0, -1, 0, 4'b0000};
    vecs[1]  = '{4'b1111, 8'd3, 3, 2'b00, 1, -1, 0, 4'b0000};
    vecs[2]  = '{4'b1111, 8'd3, 3, 2'b01, 2, -1, 0, 4'b0000};
    vecs[3]  = '{4'b1111, 8'd3, 3, 2'b00, 3, -1, 0, 4'b0000};
    vecs[4]  = '{4'b1111, 8'd3, 3, 2'b00, 0, -1, 0, 4'b0000};
    vecs[5]  = '{4'b0000, 8'd3, 3, 2'b00, 1, -1, 0, 4'b0000};
    vecs[6]  = '{4'b0000, 8'd1, 1, 2'b10, 2, -1, 0, 4'b0000};
    vecs[7]  = '{4'b0000, 8'd2, 2, 2'b00, 3, -1, 0, 4'b0000};
    vecs[8]  = '{4'b0010, 8'd1, 1, 2'b00, 1, -1, 0, 4'b0000};
    vecs[9]  = '{4'b1010, 8'd3, 3, 2'b00, 3, -1, 0, 4'b0000};
    vecs[10] = '{4'b0000, 8'd0, 0, 2'b00, 1, -1, 0, 4'b0000};
    vecs[11] = '{4'b0001, 8'd3, 1, 2'b00, 0, -1, 0, 4'b0001};
    vecs[12] = '{4'b1000, 8'd0, 9, 2'b00, 3, -1, 0, 4'b1001};
    vecs[13] = '{4'b1000, 8'd0, 9, 2'b00, 3,  0, 0, 4'b1001};
    vecs[14] = '{4'b0100, 8'd7, 7, 2'b11, 2, -1, 0, 4'b1001};
    vecs[15] = '{4'b0010, 8'd0, 0, 2'b00, 1, -1, 5, 4'b1001};

    rst_n         = 1'b0;
    s_axi_awvalid = '0;
    s_axi_wvalid  = '0;
    s_axi_wlast   = '0;
    s_axi_bready  = '0;
    clear_error   = '0;
    m_axi_awready = 1'b0;
    m_axi_wready  = 1'b0;
    m_axi_bvalid  = 1'b0;
    m_axi_bresp   = 2'b00;
    for (int p = 0; p < NP; p++) begin
      s_axi_awaddr[p] = 32'h1000_0000 + 32'(p) * 32'h100;
      s_axi_awlen[p]  = 8'd0;
      s_axi_wdata[p]  = 64'd0;
    end

    repeat (3) tick();
    checkOutput("rstGrantValid", 64'(grant_valid), 64'd0);
    checkOutput("rstGrantId", 64'(grant_id), 64'd0);
    checkOutput("rstWlastError", 64'(wlast_error), 64'd0);
    checkOutput("rstMValids", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_bready}), 64'd0);
    checkOutput("rstSReadys", 64'({s_axi_awready, s_axi_wready, s_axi_bvalid}), 64'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i]);
    end

    // Clearing one bit leaves the other sticky bit alone.
    clear_error = 4'b0001;
    tick();
    clear_error = 4'b0000;
    #1;
    checkOutput("clearPort0", 64'(wlast_error), 64'(4'b1000));
    clear_error = 4'b1000;
    tick();
    clear_error = 4'b0000;
    #1;
    checkOutput("clearPort3", 64'(wlast_error), 64'(4'b0000));

    // Reset in the middle of a burst, with a freshly set error bit.
    s_axi_awlen[0]   = 8'd3;
    s_axi_awvalid[0] = 1'b1;
    tick();
    checkOutput("midGrantValid", 64'(grant_valid), 64'd1);
    checkOutput("midGrantId", 64'(grant_id), 64'd0);
    m_axi_awready = 1'b1;
    tick();
    s_axi_awvalid[0] = 1'b0;
    m_axi_awready    = 1'b0;
    s_axi_wvalid[0]  = 1'b1;
    s_axi_wlast[0]   = 1'b1;
    s_axi_wdata[0]   = beatData(0, 0);
    m_axi_wready     = 1'b1;
    tick();
    s_axi_wlast[0] = 1'b0;
    s_axi_wdata[0] = beatData(0, 1);
    #1;
    checkOutput("midErrSet", 64'(wlast_error), 64'(4'b0001));
    checkOutput("midWvalid", 64'(m_axi_wvalid), 64'd1);
    rst_n = 1'b0;
    tick();
    checkOutput("midRstGrantValid", 64'(grant_valid), 64'd0);
    checkOutput("midRstGrantId", 64'(grant_id), 64'd0);
    checkOutput("midRstErr", 64'(wlast_error), 64'd0);
    checkOutput("midRstMValids", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_wlast}), 64'd0);
    checkOutput("midRstSReadys", 64'({s_axi_awready, s_axi_wready, s_axi_bvalid}), 64'd0);
    rst_n = 1'b1;
    tick();
    checkOutput("postRstWvalid", 64'(m_axi_wvalid), 64'd0);
    checkOutput("postRstGrantValid", 64'(grant_valid), 64'd0);
    s_axi_wvalid[0] = 1'b0;
    m_axi_wready    = 1'b0;

    // Pointer restarts at 0: ports 1 and 2 pending, port 1 wins first.
    applyStimulus('{4'b0110, 8'd2, 2, 2'b00, 1, -1, 0, 4'b0000});
    applyStimulus('{4'b0000, 8'd1, 1, 2'b01, 2, -1, 0, 4'b0000});

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
